// File: rtl/xs3_pkg.sv
// Shared definitions for excess-3 decimal decoding.
// Holds the code offset, the legal code window, the digit type and
// the state encoding used by the serial frame decoder.
package xs3_pkg;

  localparam int         XS3_OFFSET = 3;
  localparam logic [3:0] XS3_MIN    = 4'h3;
  localparam logic [3:0] XS3_MAX    = 4'hC;

  typedef logic [3:0] xs3_digit_t;

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } xs3_state_t;

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit excess-3 decoder (purely combinational).
// Maps an excess-3 code to its decimal value 0..9. Codes outside
// 4'h3..4'hC decode to 0 and raise the illegal flag, so a caller can
// keep accumulating and simply mark the frame as bad.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  xs3_digit_t in_digit,
  output logic [3:0] dec,
  output logic       illegal
);

  // Remove the excess-3 offset, forcing illegal codes to zero
  always_comb begin
    illegal = (in_digit < XS3_MIN) || (in_digit > XS3_MAX);
    dec     = illegal ? 4'd0 : (in_digit - 4'(XS3_OFFSET));
  end

endmodule

// File: rtl/xs3_to_bin_dec.sv
// Serial excess-3 decimal to binary frame decoder.
// Digits arrive most significant first, one per in_valid/in_ready
// handshake. A frame ends on in_last or after NUM_DIGITS digits; the
// binary value is then presented on the out_valid/out_ready handshake.
// Optional macro XS3_DEC_ERRCNT_EN adds a saturating count of frames
// delivered with out_invalid set.
module xs3_to_bin_dec
  import xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic [3:0]       out_ndigits,
  output logic             out_invalid
`ifdef XS3_DEC_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  xs3_state_t       state;
  xs3_state_t       state_next;
  logic [BIN_W-1:0] acc;
  logic [3:0]       cnt;
  logic             err;

  logic [3:0]       dec;
  logic             illegal;
  logic             accept;
  logic [BIN_W+3:0] acc_wide;
  logic [BIN_W-1:0] acc_next;
  logic [3:0]       cnt_inc;
  logic             count_hit;
  logic             frame_end;
  logic             err_next;

  xs3_digit_dec u_digit_dec (
    .in_digit (in_digit),
    .dec      (dec),
    .illegal  (illegal)
  );

  assign in_ready = (state == ST_ACC);
  assign accept   = in_valid && in_ready;

  // Accumulate acc*10 + d using shifts, with 4 bits of headroom before truncation
  always_comb begin
    acc_wide  = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{BIN_W{1'b0}}, dec};
    acc_next  = acc_wide[BIN_W-1:0];
    cnt_inc   = cnt + 4'd1;
    count_hit = (cnt_inc == 4'(NUM_DIGITS));
    frame_end = in_last || count_hit;
    err_next  = err || illegal || (count_hit && !in_last);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  // Next-state: leave ACC on the closing digit, leave OUT on the result handshake
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (in_valid && frame_end) state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // Frame accumulation and result capture; result fields hold after out_valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= 4'd0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_bin     <= '0;
      out_ndigits <= 4'd0;
      out_invalid <= 1'b0;
    end else if (accept) begin
      if (frame_end) begin
        acc         <= '0;
        cnt         <= 4'd0;
        err         <= 1'b0;
        out_valid   <= 1'b1;
        out_bin     <= acc_next;
        out_ndigits <= cnt_inc;
        out_invalid <= err_next;
      end else begin
        acc <= acc_next;
        cnt <= cnt_inc;
        err <= err_next;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef XS3_DEC_ERRCNT_EN
  // Count bad frames at the moment they are handed off, saturating at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (out_valid && out_ready && out_invalid && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
